// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared card constants, LFSR taps and shoe FSM states
package baccarat_pkg;
  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_ACE = 4'd1;
  localparam logic [3:0] CARD_JACK = 4'd11;
  localparam logic [3:0] CARD_QUEEN = 4'd12;
  localparam logic [3:0] CARD_KING = 4'd13;
  localparam int DECK_SIZE = 52;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {INIT, SHUFFLE, READY, EMPTY} shoe_state_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit right-shift Galois LFSR, reloads SEED on reset
module lfsr16 import baccarat_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= SEED;
    else q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/card_shoe.sv
// card_shoe: multi-deck shoe with LFSR Fisher-Yates shuffle, deals one card per request
module card_shoe import baccarat_pkg::*; #(
  parameter int NUM_DECKS = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int N = DECK_SIZE * NUM_DECKS,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          slow_clock,
  input  logic          reset,
  input  logic          shuffle_req,
  input  logic          deal,
  output logic [3:0]    new_card,
  output logic          card_valid,
  output logic          ready,
  output logic          shuffling,
  output logic          shoe_empty,
  output logic [CW-1:0] cards_left
);
  localparam int IW = $clog2(N);
  shoe_state_t state, state_d;
  logic [3:0] shoe [N];
  logic [15:0] lfsr;
  logic [IW-1:0] ptr, i, j;
  logic swap;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(slow_clock), .rst(reset), .q(lfsr));
  assign j = IW'(lfsr);
  assign swap = state == SHUFFLE && j <= i;
  assign ready = state == READY;
  assign shuffling = state == INIT || state == SHUFFLE;
  assign shoe_empty = state == EMPTY;
  always_comb
    state_d = shuffle_req ? INIT :
              state == INIT ? SHUFFLE :
              (swap && i == IW'(1)) ? READY :
              (ready && deal && cards_left == CW'(1)) ? EMPTY : state;
  always_ff @(posedge slow_clock or posedge reset)
    if (reset) state <= INIT;
    else state <= state_d;
  always_ff @(posedge slow_clock or posedge reset)
    if (reset) begin
      new_card <= CARD_NONE;
      card_valid <= 1'b0;
      cards_left <= CW'(N);
      ptr <= '0;
      i <= IW'(N - 1);
    end else begin
      card_valid <= ~shuffle_req & ready & deal;
      if (shuffle_req || state == INIT) begin
        ptr <= '0;
        cards_left <= CW'(N);
        i <= IW'(N - 1);
      end
      if (shuffle_req) new_card <= CARD_NONE;
      else if (ready && deal) begin
        new_card <= shoe[ptr];
        ptr <= ptr + 1'b1;
        cards_left <= cards_left - 1'b1;
      end else if (swap) i <= i - 1'b1;
    end
  // Shoe contents are fully rewritten in INIT, so they need no reset of their own
  always_ff @(posedge slow_clock)
    if (state == INIT)
      for (int k = 0; k < N; k++) shoe[k] <= 4'((k % 13) + CARD_ACE);
    else if (swap && !shuffle_req) begin
      shoe[i] <= shoe[j];
      shoe[j] <= shoe[i];
    end
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed and table-driven checks of card_shoe against a shuffle reference model
module tb_card_shoe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sreq1 = 1'b0, deal1 = 1'b0, sreq2 = 1'b0, deal2 = 1'b0;
  logic [3:0] card1, card2;
  logic v1, v2, r1, r2, s1, s2, e1, e2;
  logic [5:0] left1;
  logic [6:0] left2;

  always #5 clk = ~clk;

  card_shoe #(.NUM_DECKS(1)) dut1 (
    .slow_clock(clk), .reset(rst), .shuffle_req(sreq1), .deal(deal1),
    .new_card(card1), .card_valid(v1), .ready(r1), .shuffling(s1),
    .shoe_empty(e1), .cards_left(left1)
  );
  card_shoe #(.NUM_DECKS(2)) dut2 (
    .slow_clock(clk), .reset(rst), .shuffle_req(sreq2), .deal(deal2),
    .new_card(card2), .card_valid(v2), .ready(r2), .shuffling(s2),
    .shoe_empty(e2), .cards_left(left2)
  );

  typedef struct {
    logic deal;
    logic sreq;
    logic exp_valid;
    int   exp_card;
    int   exp_left;
    logic exp_ready;
    logic exp_shuf;
  } vec_t;

  int n_checks = 0, n_fail = 0;
  int cyc1, cyc2, cnt, bad;
  int hist[14];
  logic [3:0] mord[104], exp1[52], exp2[104], seq1[52];
  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0);
  endfunction

  // Reference Fisher-Yates: INIT consumes one LFSR step, then one candidate per cycle
  task automatic run_model(input int n, output int cyc);
    logic [15:0] l;
    logic [3:0] t;
    int i, j, mask;
    mask = (n == 52) ? 63 : 127;
    for (int k = 0; k < n; k++) mord[k] = 4'((k % 13) + 1);
    l = nxt(16'hACE1);
    i = n - 1;
    cyc = 0;
    while (i > 0) begin
      j = int'(l) & mask;
      if (j <= i) begin
        t = mord[i];
        mord[i] = mord[j];
        mord[j] = t;
        i--;
      end
      l = nxt(l);
      cyc++;
    end
  endtask

  task automatic wait_ready1(output int c);
    c = 0;
    while (!r1 && c < 5000) begin
      tick();
      c++;
    end
  endtask

  initial begin
    run_model(52, cyc1);
    for (int k = 0; k < 52; k++) exp1[k] = mord[k];
    run_model(104, cyc2);
    for (int k = 0; k < 104; k++) exp2[k] = mord[k];
    for (int k = 0; k < 12; k++) begin
      vecs[k] = '{deal: 1'b1, sreq: 1'b0, exp_valid: 1'b1, exp_card: 0,
                  exp_left: 0, exp_ready: 1'b1, exp_shuf: 1'b0};
    end
    for (int k = 0; k < 2; k++) begin
      vecs[k].exp_card = exp1[k];
      vecs[k].exp_left = 51 - k;
    end
    vecs[2] = '{1'b0, 1'b0, 1'b0, exp1[1], 50, 1'b1, 1'b0};
    for (int k = 3; k < 11; k++) begin
      vecs[k].exp_card = exp1[k - 1];
      vecs[k].exp_left = 52 - k;
    end
    vecs[11] = '{1'b1, 1'b1, 1'b0, 0, 52, 1'b0, 1'b1};

    tick();
    chk("rst_card", card1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_ready", r1, 0);
    chk("rst_shuf", s1, 1);
    chk("rst_empty", e1, 0);
    chk("rst_left", left1, 52);
    rst = 1'b0;
    cnt = 0;
    bad = 0;
    while (!r1 && cnt < 5000) begin
      tick();
      cnt++;
      if (!r1 && (!s1 || left1 != 52 || card1 != 0)) bad++;
    end
    chk("ready_cycles", cnt, cyc1 + 1);
    chk("shuffle_flags", bad, 0);
    chk("ready_card", card1, 0);

    for (int k = 0; k < 14; k++) hist[k] = 0;
    deal1 = 1'b1;
    for (int k = 0; k < 52; k++) begin
      tick();
      chk("deal_valid", v1, 1);
      chk("deal_card", card1, exp1[k]);
      chk("deal_left", left1, 51 - k);
      seq1[k] = card1;
      if (card1 <= 13) hist[card1]++;
    end
    chk("rank_none", hist[0], 0);
    for (int r = 1; r <= 13; r++) chk($sformatf("rank%0d_count", r), hist[r], 4);
    chk("empty_flag", e1, 1);
    chk("empty_ready", r1, 0);
    tick();
    chk("empty_valid", v1, 0);
    chk("empty_card", card1, exp1[51]);
    chk("empty_left", left1, 0);
    chk("empty_hold", e1, 1);
    deal1 = 1'b0;

    sreq1 = 1'b1;
    tick();
    sreq1 = 1'b0;
    chk("sreq_shuf", s1, 1);
    chk("sreq_left", left1, 52);
    chk("sreq_card", card1, 0);
    chk("sreq_empty", e1, 0);
    tick();
    tick();
    chk("mid_shuf", s1, 1);
    rst = 1'b1;
    #1;
    chk("async_card", card1, 0);
    chk("async_shuf", s1, 1);
    chk("async_ready", r1, 0);
    tick();
    rst = 1'b0;
    wait_ready1(cnt);
    chk("reshuffle_cycles", cnt, cyc1 + 1);

    foreach (vecs[k]) begin
      deal1 = vecs[k].deal;
      sreq1 = vecs[k].sreq;
      tick();
      chk($sformatf("vec%0d_valid", k), v1, vecs[k].exp_valid);
      chk($sformatf("vec%0d_card", k), card1, vecs[k].exp_card);
      chk($sformatf("vec%0d_left", k), left1, vecs[k].exp_left);
      chk($sformatf("vec%0d_ready", k), r1, vecs[k].exp_ready);
      chk($sformatf("vec%0d_shuf", k), s1, vecs[k].exp_shuf);
    end
    deal1 = 1'b0;
    sreq1 = 1'b0;
    wait_ready1(cnt);
    chk("sreq_ready", r1, 1);

    sreq1 = 1'b1;
    tick();
    sreq1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready1(cnt);
    chk("determ_cycles", cnt, cyc1 + 1);
    deal1 = 1'b1;
    bad = 0;
    for (int k = 0; k < 52; k++) begin
      tick();
      if (!v1 || card1 != seq1[k]) bad++;
    end
    chk("determ_seq", bad, 0);
    deal1 = 1'b0;

    rst = 1'b1;
    #1;
    chk("d2_rst_left", left2, 104);
    tick();
    deal2 = 1'b1;
    rst = 1'b0;
    cnt = 0;
    bad = 0;
    while (!r2 && cnt < 5000) begin
      tick();
      cnt++;
      if (v2 || (!r2 && left2 != 104)) bad++;
    end
    chk("d2_ready_cycles", cnt, cyc2 + 1);
    chk("d2_ignored_deals", bad, 0);
    for (int k = 0; k < 14; k++) hist[k] = 0;
    bad = 0;
    for (int k = 0; k < 104; k++) begin
      tick();
      if (!v2 || card2 != exp2[k] || left2 != 7'(103 - k)) bad++;
      if (card2 <= 13) hist[card2]++;
    end
    chk("d2_deal_seq", bad, 0);
    for (int r = 1; r <= 13; r++) chk($sformatf("d2_rank%0d_count", r), hist[r], 8);
    chk("d2_empty", e2, 1);
    chk("d2_left", left2, 0);
    deal2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Upstream card source for the Baccarat datapath.
- Holds one or more 52-card decks and shuffles them without replacement using a deterministic LFSR Fisher-Yates pass.
- Deals one 4-bit card per request into the hand registers that the dealer state machine loads.
- Reports cards remaining and empty status so the game controller can request a reshuffle.

Parameters:
- NUM_DECKS, 1, number of 52-card decks in the shoe (legal 1..8); N = 52*NUM_DECKS.
- LFSR_SEED, 16'hACE1, nonzero LFSR value loaded on reset.

Ports:
- slow_clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- shuffle_req  in  1  level-sampled; restart the shoe (refill and reshuffle).
- deal  in  1  request one card; sampled each rising edge.
- new_card  out  4  last dealt card: 1=Ace, 2..10, 11=J, 12=Q, 13=K; 0=no card.
- card_valid  out  1  one-cycle pulse, high in the cycle after an accepted deal.
- ready  out  1  high only in READY; deals are accepted only then.
- shuffling  out  1  high in INIT or SHUFFLE.
- shoe_empty  out  1  high in EMPTY.
- cards_left  out  CW  undealt cards, where CW = $clog2(N+1).

Behaviour:
- Reset values (async): state=INIT, new_card=0, card_valid=0, ready=0, shuffling=1, shoe_empty=0, cards_left=N, lfsr=LFSR_SEED, ptr=0.
- Storage: register array shoe[0..N-1] of 4 bits each; IW = $clog2(N) index bits.
- LFSR: 16-bit Galois, taps mask 16'hB400, right shift.
  - Advances every clock edge when not in reset, regardless of state.
  - Never reaches 0.
- INIT, 1 cycle:
  - shoe[k] = (k mod 13)+1 for all k.
  - ptr=0, cards_left=N, i=N-1.
  - Next state: SHUFFLE.
- SHUFFLE, one candidate per cycle:
  - j = lfsr[IW-1:0].
  - If j <= i: swap shoe[i] and shoe[j], then i=i-1.
  - Otherwise (j > i): reject and retry next cycle.
  - When i reaches 0 after a swap, go to READY.
  - Duration is variable but fully deterministic for a given seed.
- READY, on deal=1:
  - new_card <= shoe[ptr], card_valid <= 1 on the next cycle (1-cycle latency).
  - ptr++, cards_left--.
  - If cards_left becomes 0, go to EMPTY.
- READY, on deal=0: card_valid=0; new_card holds its last value.
- EMPTY: deal is ignored with no pulse; new_card holds; stays in EMPTY until shuffle_req or reset.
- shuffle_req=1 in any state goes to INIT on the next edge.
  - It has priority over deal in the same cycle: no card dealt, card_valid=0.
  - new_card is cleared to 0.
- deal asserted in INIT, SHUFFLE or EMPTY: ignored; no queuing.
- Back-to-back deals: one card per cycle while ready; held deal=1 deals every cycle.
- Reset mid-shuffle or mid-deal: immediate return to reset values; the LFSR reloads the seed, so the post-reset shuffle is identical to the first one.
- Flags: ready, shuffling and shoe_empty are decoded from state and are mutually exclusive.
- Invariant: after SHUFFLE completes, the shoe contains exactly 4*NUM_DECKS of each rank 1..13.

Decomposition:
- Shared package baccarat_pkg holds:
  - card constants CARD_NONE=0, CARD_ACE=1, CARD_JACK=11, CARD_QUEEN=12, CARD_KING=13, DECK_SIZE=52;
  - LFSR_TAPS=16'hB400;
  - shoe_state_t enum {INIT, SHUFFLE, READY, EMPTY}.
- One sub-module, lfsr16: clock, async reset, seed parameter, 16-bit state output, free-running.

Test Plan:
- Reset, then wait for ready -> shuffling=1 with cards_left=52 until ready rises; the number of cycles matches a reference model seeded with 16'hACE1; new_card=0.
- Hold deal=1 for 52 cycles after ready -> 52 card_valid pulses, each value in 1..13, each rank appearing exactly 4 times; cards_left steps 52..0; shoe_empty=1 and ready=0 after the 52nd pulse.
- A 53rd deal while empty -> no card_valid; new_card holds the 52nd value; cards_left=0.
- Deal 10 cards, then assert shuffle_req together with deal -> no pulse that cycle; new_card=0, cards_left=52, shuffling=1; later ready=1.
- Assert reset mid-SHUFFLE, release, deal all cards -> the sequence is identical to the first post-reset sequence (determinism check).
- NUM_DECKS=2 -> cards_left starts at 104; after a full deal each rank appears exactly 8 times; deal pulses during shuffling are ignored.
